z88_mem_arbiter: RTL and testbench
==================================

Name: z88_mem_arbiter

Overview:
- Shares the single external RAM/ROM bus between two requesters.
  - Z80 CPU: 22-bit banked address, already segment-translated.
  - LCD screen-fetch engine.
- Sequences every memory access with fixed-length strobes.
- Stalls the CPU via wait_n while the bus is busy.
- Guarantees bounded CPU latency against continuous LCD fetch.
- Sits between the Blink address translation and the external memory pins.

Parameters:
- ACCESS_CYCLES, 2: cycles the strobes are held per access; legal range 1..15.
- LCD_MAX_BURST, 4: max consecutive LCD grants while a CPU request is pending; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cpu_mreq_n  in  1  Z80 memory request
- cpu_rd_n  in  1  Z80 read strobe
- cpu_wr_n  in  1  Z80 write strobe
- cpu_addr  in  22  translated CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data
- cpu_wait_n  out  1  Z80 wait, combinational
- lcd_req  in  1  LCD fetch request, level
- lcd_addr  in  22  LCD fetch address
- lcd_ack  out  1  one-cycle completion pulse
- lcd_rdata  out  8  LCD read data, valid with lcd_ack
- mem_a  out  19  external address
- mem_do  out  8  external write data
- ram_di  in  8  RAM read data
- rom_di  in  8  ROM read data
- ram_ce_n  out  1  RAM chip enable
- rom_ce_n  out  1  ROM chip enable
- mem_oe_n  out  1  shared output enable
- mem_we_n  out  1  shared write enable

Behaviour:
- cpu_req = !cpu_mreq_n & (!cpu_rd_n | !cpu_wr_n).
- Region decode on addr[21:19]:
  - 000 = ROM.
  - 001 = RAM.
  - otherwise unmapped: no strobes asserted, read data 0xFF.
- Writes to ROM: rom_ce_n and mem_we_n stay high; the access still completes.
- States: IDLE, CPU_ACC, LCD_ACC, CPU_DONE. Strobes, mem_a, mem_do, lcd_ack, lcd_rdata and cpu_rdata are all registered.
- IDLE arbitration:
  - Only lcd_req: grant LCD.
  - Only cpu_req: grant CPU.
  - Both: grant LCD unless lcd_run == LCD_MAX_BURST, in which case grant CPU.
  - Address, data and direction are sampled at the grant edge only; later changes are ignored.
- Access timing, with grant decided in cycle T:
  - Strobes asserted in cycles T+1..T+ACCESS_CYCLES.
  - ce_n for the decoded region, oe_n for a read, we_n for a write.
  - Read data captured at the end of T+ACCESS_CYCLES.
- LCD completion: state returns to IDLE at T+ACCESS_CYCLES+1. lcd_ack=1 and lcd_rdata are valid for that one cycle, and a new grant may be decided in that same cycle.
- CPU completion: state enters CPU_DONE at T+ACCESS_CYCLES+1 with cpu_rdata valid. It stays in CPU_DONE while cpu_req=1 and goes to IDLE the cycle after cpu_req=0. Exactly one access is made per mreq assertion.
- cpu_wait_n = !(cpu_req & state != CPU_DONE). It goes low in the same cycle the request appears, including while an LCD access is in progress.
- Minimum bus turnaround: one strobe-free cycle between consecutive accesses.
- lcd_run, 4-bit:
  - Increments on an LCD grant made while cpu_req=1.
  - Clears on a CPU grant, or in IDLE with cpu_req=0.
  - Saturates at LCD_MAX_BURST.
- Reset, including mid-access:
  - State goes to IDLE; all ce_n/oe_n/we_n = 1.
  - mem_a=0, mem_do=0, lcd_ack=0, lcd_rdata=0x00, cpu_rdata=0xFF, lcd_run=0.
  - No ack is issued for an aborted access.
  - A CPU request held through reset is regranted afterwards.
- lcd_req dropped before grant: no access. lcd_req may stay high across ack; it is treated as a new request.

Decomposition:
- Package z88_mem_pkg:
  - Region constants REGION_ROM=3'b000, REGION_RAM=3'b001.
  - State encoding.
  - Unmapped read value 8'hFF.
- One sub-module, z88_region_decode: maps a 22-bit address to rom_sel/ram_sel. It is instantiated once, on the granted-address mux.

Test Plan (ACCESS_CYCLES=2, LCD_MAX_BURST=4):
- CPU read 0x080123, ram_di=0x5A -> cpu_wait_n low T..T+2; ram_ce_n and mem_oe_n low T+1..T+2; mem_a=0x00123; cpu_rdata=0x5A and wait_n high at T+3.
- LCD read 0x000040, rom_di=0xC3 -> rom_ce_n low T+1..T+2; lcd_ack pulse at T+3 with lcd_rdata=0xC3.
- lcd_req and CPU write 0x080010/0xA5 both raised at T -> LCD strobes T+1..T+2, ack T+3; RAM we_n low T+4..T+5 with mem_do=0xA5; wait_n high T+6.
- lcd_req held high plus CPU read pending -> exactly 4 LCD accesses, then the CPU access, then LCD resumes.
- CPU write 0x000010 (ROM) -> no ce_n/we_n asserted, completes at T+3; CPU read 0x200000 -> cpu_rdata=0xFF, no strobes.
- reset_n low during T+1 of an LCD access -> all strobes high next cycle, no lcd_ack, state IDLE.

Source files
------------

// File: rtl/z88_mem_pkg.sv
// Shared constants and types for the Z88 memory arbiter: region codes,
// arbiter state encoding, the unmapped read value and the strobe bundle.
package z88_mem_pkg;

    // Region codes found in address bits [21:19].
    localparam logic [2:0] REGION_ROM = 3'b000;
    localparam logic [2:0] REGION_RAM = 3'b001;

    // Arbiter state encoding, kept as plain constants so older blocks that
    // compare raw state values keep working.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CPU_ACC  = 2'd1;
    localparam logic [1:0] ST_LCD_ACC  = 2'd2;
    localparam logic [1:0] ST_CPU_DONE = 2'd3;

    // Value returned for reads outside ROM and RAM.
    localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;

    // External bus strobes, all active-low.
    typedef struct packed {
        logic ram_ce_n;
        logic rom_ce_n;
        logic oe_n;
        logic we_n;
    } strobe_t;

    localparam strobe_t STROBES_OFF = '{ram_ce_n: 1'b1, rom_ce_n: 1'b1,
                                        oe_n: 1'b1, we_n: 1'b1};

    // Strobe pattern for one access. ROM is never written, so a ROM write
    // leaves every strobe inactive; unmapped accesses assert nothing.
    function automatic strobe_t access_strobes(input logic rom_sel,
                                               input logic ram_sel,
                                               input logic wr);
        strobe_t s;
        s          = STROBES_OFF;
        s.rom_ce_n = !(rom_sel && !wr);
        s.ram_ce_n = !ram_sel;
        s.oe_n     = !((rom_sel || ram_sel) && !wr);
        s.we_n     = !(ram_sel && wr);
        return s;
    endfunction

endpackage

// File: rtl/z88_region_decode.sv
// Decodes a translated 22-bit Z88 address into ROM / RAM chip selects.
// Anything outside the two regions selects neither device.
module z88_region_decode
    import z88_mem_pkg::*;
(
    input  logic [21:0] addr_i,
    output logic        rom_sel_o,
    output logic        ram_sel_o
);

    assign rom_sel_o = (addr_i[21:19] == REGION_ROM);
    assign ram_sel_o = (addr_i[21:19] == REGION_RAM);

endmodule

// File: rtl/z88_mem_arbiter.sv
// Z88 external memory arbiter: shares the RAM/ROM bus between the Z80 and
// the LCD fetch engine, sequences fixed-length strobes, stalls the CPU with
// wait_n and bounds CPU latency by limiting back-to-back LCD grants.
module z88_mem_arbiter
    import z88_mem_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned LCD_MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait_n,
    input  logic        lcd_req,
    input  logic [21:0] lcd_addr,
    output logic        lcd_ack,
    output logic [7:0]  lcd_rdata,
    output logic [18:0] mem_a,
    output logic [7:0]  mem_do,
    input  logic [7:0]  ram_di,
    input  logic [7:0]  rom_di,
    output logic        ram_ce_n,
    output logic        rom_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n
);

    localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES);
    localparam logic [3:0] RUN_MAX  = 4'(LCD_MAX_BURST);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;          // strobe cycle within the access, 1-based
    logic [3:0]  run_q, run_d;          // LCD grants made while the CPU waits
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rom_sel_q, rom_sel_d;
    logic        ram_sel_q, ram_sel_d;
    logic        wr_q, wr_d;
    strobe_t     strobe_q, strobe_d;
    logic        lcd_ack_q, lcd_ack_d;
    logic [7:0]  lcd_rdata_q, lcd_rdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;

    logic        cpu_req;
    logic        grant_lcd;
    logic        grant_cpu;
    logic [21:0] gnt_addr;
    logic        gnt_rom_sel;
    logic        gnt_ram_sel;
    logic        gnt_wr;
    logic        last_cycle;
    logic [7:0]  bus_rdata;

    assign cpu_req = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);

    // The CPU sees wait as soon as it asks, even mid LCD access, and is
    // released only once its own access has completed.
    assign cpu_wait_n = !(cpu_req && (state_q != ST_CPU_DONE));

    // LCD wins ties until it has used up its burst allowance against a
    // waiting CPU; run_q saturates at RUN_MAX so inequality is enough.
    assign grant_lcd = (state_q == ST_IDLE) && lcd_req &&
                       (!cpu_req || (run_q != RUN_MAX));
    assign grant_cpu = (state_q == ST_IDLE) && cpu_req && !grant_lcd;

    // One decoder serves both requesters through the granted-address mux.
    assign gnt_addr = grant_cpu ? cpu_addr : lcd_addr;
    assign gnt_wr   = grant_cpu && !cpu_wr_n;

    z88_region_decode u_decode (
        .addr_i    (gnt_addr),
        .rom_sel_o (gnt_rom_sel),
        .ram_sel_o (gnt_ram_sel)
    );

    assign last_cycle = (cnt_q == ACC_LAST);
    assign bus_rdata  = rom_sel_q ? rom_di :
                        (ram_sel_q ? ram_di : UNMAPPED_RDATA);

    // Next-state logic: arbitration, access sequencing and data capture.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rom_sel_d   = rom_sel_q;
        ram_sel_d   = ram_sel_q;
        wr_d        = wr_q;
        strobe_d    = strobe_q;
        lcd_ack_d   = 1'b0;
        lcd_rdata_d = lcd_rdata_q;
        cpu_rdata_d = cpu_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_cpu || grant_lcd) begin
                    // Address, data and direction are frozen here.
                    state_d   = grant_cpu ? ST_CPU_ACC : ST_LCD_ACC;
                    cnt_d     = 4'd1;
                    addr_d    = gnt_addr[18:0];
                    rom_sel_d = gnt_rom_sel;
                    ram_sel_d = gnt_ram_sel;
                    wr_d      = gnt_wr;
                    strobe_d  = access_strobes(gnt_rom_sel, gnt_ram_sel, gnt_wr);
                    if (grant_cpu) begin
                        wdata_d = cpu_wdata;
                    end
                end

                if (grant_cpu || !cpu_req) begin
                    run_d = 4'd0;
                end else if (grant_lcd) begin
                    run_d = (run_q == RUN_MAX) ? run_q : run_q + 4'd1;
                end
            end

            ST_CPU_ACC, ST_LCD_ACC: begin
                if (last_cycle) begin
                    // Strobes drop here, giving the turnaround cycle.
                    strobe_d = STROBES_OFF;
                    if (state_q == ST_CPU_ACC) begin
                        state_d = ST_CPU_DONE;
                        if (!wr_q) begin
                            cpu_rdata_d = bus_rdata;
                        end
                    end else begin
                        state_d     = ST_IDLE;
                        lcd_ack_d   = 1'b1;
                        lcd_rdata_d = bus_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_CPU_DONE: begin
                // Hold until the CPU ends its cycle: one access per mreq.
                if (!cpu_req) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge values, so ordering between statements does not matter.
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            run_q       <= 4'd0;
            addr_q      <= 19'd0;
            wdata_q     <= 8'd0;
            rom_sel_q   <= 1'b0;
            ram_sel_q   <= 1'b0;
            wr_q        <= 1'b0;
            strobe_q    <= STROBES_OFF;
            lcd_ack_q   <= 1'b0;
            lcd_rdata_q <= 8'h00;
            cpu_rdata_q <= UNMAPPED_RDATA;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rom_sel_q   <= rom_sel_d;
            ram_sel_q   <= ram_sel_d;
            wr_q        <= wr_d;
            strobe_q    <= strobe_d;
            lcd_ack_q   <= lcd_ack_d;
            lcd_rdata_q <= lcd_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign mem_a     = addr_q;
    assign mem_do    = wdata_q;
    assign ram_ce_n  = strobe_q.ram_ce_n;
    assign rom_ce_n  = strobe_q.rom_ce_n;
    assign mem_oe_n  = strobe_q.oe_n;
    assign mem_we_n  = strobe_q.we_n;
    assign lcd_ack   = lcd_ack_q;
    assign lcd_rdata = lcd_rdata_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_z88_mem_arbiter.sv
// Self-checking bench for z88_mem_arbiter: directed timing checks plus
// randomized CPU/LCD traffic scored against a region-level memory model.
module tb_z88_mem_arbiter;

    localparam int ACC     = 2;
    localparam int BURST   = 4;
    localparam int LAT_MAX = (BURST + 2) * (ACC + 1);

    // Strobe snapshots {ram_ce_n, rom_ce_n, oe_n, we_n}.
    localparam logic [3:0] S_NONE   = 4'b1111;
    localparam logic [3:0] S_RAM_RD = 4'b0101;
    localparam logic [3:0] S_ROM_RD = 4'b1001;
    localparam logic [3:0] S_RAM_WR = 4'b0110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
    logic [21:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait_n;
    logic        lcd_req;
    logic [21:0] lcd_addr;
    logic        lcd_ack;
    logic [7:0]  lcd_rdata;
    logic [18:0] mem_a;
    logic [7:0]  mem_do;
    logic [7:0]  ram_di = 8'hEE;
    logic [7:0]  rom_di = 8'hEE;
    logic        ram_ce_n, rom_ce_n, mem_oe_n, mem_we_n;

    z88_mem_arbiter #(.ACCESS_CYCLES(ACC), .LCD_MAX_BURST(BURST)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_wait_n(cpu_wait_n),
        .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_ack(lcd_ack),
        .lcd_rdata(lcd_rdata),
        .mem_a(mem_a), .mem_do(mem_do), .ram_di(ram_di), .rom_di(rom_di),
        .ram_ce_n(ram_ce_n), .rom_ce_n(rom_ce_n),
        .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] data;
    } cpu_exp_t;

    cpu_exp_t   cpu_q[$];
    logic [7:0] lcd_q[$];
    logic [7:0] ram_ref [int];   // CPU writes as the model sees them
    int         tests = 0;
    int         fails = 0;
    int         lcd_ack_cnt = 0;
    logic       cpu_seen = 1'b0;
    logic       sim_done = 1'b0;

    // Background contents of the two devices.
    function automatic logic [7:0] rom_pat(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h83;
    endfunction

    function automatic logic [7:0] ram_pat(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h78;
    endfunction

    // What a read of a 22-bit address must return, from the region rules.
    function automatic logic [7:0] exp_read(input logic [21:0] a);
        case (a[21:19])
            3'b000:  return rom_pat(a[18:0]);
            3'b001:  return ram_ref.exists(int'(a[18:0])) ? ram_ref[int'(a[18:0])]
                                                          : ram_pat(a[18:0]);
            default: return 8'hFF;
        endcase
    endfunction

    // External memory devices, responding to the strobes of the current cycle.
    logic [255:0] wr_vld = '0;
    logic [7:0]   wr_data [256];
    always @(posedge clk) begin
        #2;
        if (!ram_ce_n && !mem_we_n && mem_a[18:8] == 11'd0) begin
            wr_vld[mem_a[7:0]]  <= 1'b1;
            wr_data[mem_a[7:0]] <= mem_do;
        end
        if (!ram_ce_n && !mem_oe_n)
            ram_di <= (mem_a[18:8] == 11'd0 && wr_vld[mem_a[7:0]]) ? wr_data[mem_a[7:0]]
                                                                   : ram_pat(mem_a);
        else
            ram_di <= 8'hEE;
        rom_di <= (!rom_ce_n && !mem_oe_n) ? rom_pat(mem_a) : 8'hEE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strb();
        return {ram_ce_n, rom_ce_n, mem_oe_n, mem_we_n};
    endfunction

    task automatic cpu_set(input logic wr, input logic [21:0] a, input logic [7:0] d);
        cpu_exp_t e;
        e.wr = wr;
        e.data = exp_read(a);
        cpu_q.push_back(e);
        if (wr && a[21:19] == 3'b001) ram_ref[int'(a[18:0])] = d;
        cpu_addr   = a;
        cpu_wdata  = d;
        cpu_rd_n   = wr;
        cpu_wr_n   = !wr;
        cpu_mreq_n = 1'b0;
    endtask

    task automatic cpu_release();
        cpu_mreq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
    endtask

    task automatic lcd_set(input logic [21:0] a);
        lcd_q.push_back(exp_read(a));
        lcd_addr = a;
        lcd_req  = 1'b1;
    endtask

    // Full CPU cycle: request, wait for wait_n, hold one cycle, release.
    task automatic cpu_op(input logic wr, input logic [21:0] a, input logic [7:0] d,
                          output int lat);
        cpu_set(wr, a, d);
        #1;
        lat = 0;
        while (!cpu_wait_n && lat < 100) begin
            step();
            lat++;
        end
        if (!cpu_wait_n) check("cpu_timeout", 32'(cpu_wait_n), 1);
        step();
        cpu_release();
        step();
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT completes.
    task automatic monitor_cycle();
        cpu_exp_t e;
        logic [7:0] le;
        @(negedge clk);
        if (lcd_ack === 1'b1) begin
            lcd_ack_cnt++;
            if (lcd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL lcd_unexpected_ack: got ack with rdata 0x%0h, expected none", lcd_rdata);
            end else begin
                le = lcd_q.pop_front();
                check("lcd_rdata", 32'(lcd_rdata), 32'(le));
            end
        end
        if (!cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n)) begin
            if (cpu_wait_n === 1'b1 && !cpu_seen) begin
                cpu_seen = 1'b1;
                if (cpu_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cpu_unexpected_done: got completion, expected none");
                end else begin
                    e = cpu_q.pop_front();
                    if (!e.wr) check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                end
            end
        end else begin
            cpu_seen = 1'b0;
        end
        if (mem_we_n === 1'b0) check("we_strobe_combo", 32'(strb()), 32'(S_RAM_WR));
        if (mem_oe_n === 1'b0) check("oe_single_ce", 32'(ram_ce_n ^ rom_ce_n), 1);
    endtask

    task automatic cpu_rand(input int n);
        int lat;
        int r;
        logic [21:0] a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) step();
            r = $urandom_range(0, 9);
            if (r < 3)      a = {3'b000, 19'($urandom)};
            else if (r < 8) a = {3'b001, 11'd0, 8'($urandom_range(0, 31))};
            else            a = {3'($urandom_range(2, 7)), 19'($urandom)};
            cpu_op(1'($urandom_range(0, 1)), a, 8'($urandom), lat);
            check("cpu_latency_bound", 32'(lat <= LAT_MAX), 1);
        end
    endtask

    task automatic lcd_rand(input int n);
        int i = 0;
        int k;
        logic active = 1'b0;
        while (i < n) begin
            if (!active) repeat ($urandom_range(1, 4)) step();
            lcd_set(($urandom_range(0, 1) != 0) ? {3'b000, 19'($urandom)}
                                                : {3'b001, 1'b1, 18'($urandom)});
            i++;
            k = 0;
            do begin
                step();
                k++;
            end while (!lcd_ack && k < 100);
            if (!lcd_ack) check("lcd_timeout", 32'(lcd_ack), 1);
            active = 1'($urandom_range(0, 1));
            if (!active) lcd_req = 1'b0;
        end
        lcd_req = 1'b0;
    endtask

    task automatic main_seq();
        int acks;
        int lat;
        int cnt0;
        int k;
        logic done;

        reset_n = 1'b0;
        cpu_release();
        cpu_addr = '0;
        cpu_wdata = '0;
        lcd_req = 1'b0;
        lcd_addr = '0;
        repeat (3) step();
        check("rst_strobes", 32'(strb()), 32'(S_NONE));
        check("rst_mem_a", 32'(mem_a), 0);
        check("rst_mem_do", 32'(mem_do), 0);
        check("rst_lcd_ack", 32'(lcd_ack), 0);
        check("rst_lcd_rdata", 32'(lcd_rdata), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h FF);
        check("rst_wait_n", 32'(cpu_wait_n), 1);
        reset_n = 1'b1;
        step();

        // CPU read from RAM.
        cpu_set(1'b0, 22'h080123, 8'h00);
        #1;
        check("t1_wait_T", 32'(cpu_wait_n), 0);
        for (int c = 1; c <= ACC; c++) begin
            step();
            check("t1_strobes", 32'(strb()), 32'(S_RAM_RD));
            check("t1_mem_a", 32'(mem_a), 32'h00123);
            check("t1_wait", 32'(cpu_wait_n), 0);
        end
        step();
        check("t1_wait_done", 32'(cpu_wait_n), 1);
        check("t1_rdata", 32'(cpu_rdata), 32'h5A);
        check("t1_strobes_off", 32'(strb()), 32'(S_NONE));
        step();
        cpu_release();
        step();

        // LCD read from ROM.
        lcd_set(22'h000040);
        for (int c = 1; c <= ACC; c++) begin
            step();
            check("t2_strobes", 32'(strb()), 32'(S_ROM_RD));
            check("t2_ack_early", 32'(lcd_ack), 0);
        end
        step();
        check("t2_ack", 32'(lcd_ack), 1);
        check("t2_rdata", 32'(lcd_rdata), 32'hC3);
        lcd_req = 1'b0;
        step();
        check("t2_ack_pulse", 32'(lcd_ack), 0);

        // Simultaneous LCD read and CPU write: LCD first, then the write.
        lcd_set(22'h000100);
        cpu_set(1'b1, 22'h080010, 8'hA5);
        #1;
        check("t3_wait_T", 32'(cpu_wait_n), 0);
        for (int c = 1; c <= ACC; c++) begin
            step();
            check("t3_lcd_strobes", 32'(strb()), 32'(S_ROM_RD));
            check("t3_wait_lcd", 32'(cpu_wait_n), 0);
        end
        step();
        check("t3_ack", 32'(lcd_ack), 1);
        check("t3_turnaround", 32'(strb()), 32'(S_NONE));
        lcd_req = 1'b0;
        for (int c = 1; c <= ACC; c++) begin
            step();
            check("t3_wr_strobes", 32'(strb()), 32'(S_RAM_WR));
            check("t3_mem_do", 32'(mem_do), 32'hA5);
            check("t3_mem_a", 32'(mem_a), 32'h00010);
            check("t3_wait_wr", 32'(cpu_wait_n), 0);
        end
        step();
        check("t3_wait_done", 32'(cpu_wait_n), 1);
        step();
        cpu_release();
        step();
        cpu_op(1'b0, 22'h080010, 8'h00, lat);

        // Continuous LCD against a pending CPU read: burst limit, then resume.
        lcd_set(22'h000200);
        cpu_set(1'b0, 22'h080124, 8'h00);
        acks = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            step();
            if (lcd_ack) begin
                acks++;
                lcd_set(22'h000200 + 22'(acks));
            end
            if (cpu_wait_n) done = 1'b1;
        end
        check("t4_cpu_done", 32'(done), 1);
        check("t4_burst_count", 32'(acks), BURST);
        step();
        cpu_release();
        k = 0;
        do begin
            step();
            k++;
        end while (!lcd_ack && k < 20);
        check("t4_lcd_resumed", 32'(lcd_ack), 1);
        lcd_req = 1'b0;
        step();

        // ROM write: no strobes, still completes on time.
        cpu_set(1'b1, 22'h000010, 8'h77);
        for (int c = 1; c <= ACC; c++) begin
            step();
            check("t5_rom_wr_strobes", 32'(strb()), 32'(S_NONE));
        end
        step();
        check("t5_rom_wr_done", 32'(cpu_wait_n), 1);
        step();
        cpu_release();
        step();

        // Unmapped read returns 0xFF with no strobes.
        cpu_set(1'b0, 22'h200000, 8'h00);
        for (int c = 1; c <= ACC; c++) begin
            step();
            check("t5_unmapped_strobes", 32'(strb()), 32'(S_NONE));
        end
        step();
        check("t5_unmapped_done", 32'(cpu_wait_n), 1);
        check("t5_unmapped_rdata", 32'(cpu_rdata), 32'hFF);
        step();
        cpu_release();
        step();

        // LCD request withdrawn while the bus is busy: no LCD access.
        cpu_set(1'b0, 22'h080123, 8'h00);
        step();
        lcd_addr = 22'h000300;
        lcd_req = 1'b1;
        step();
        lcd_req = 1'b0;
        cnt0 = lcd_ack_cnt;
        k = 0;
        while (!cpu_wait_n && k < 20) begin
            step();
            k++;
        end
        step();
        cpu_release();
        repeat (6) step();
        check("t6_no_ack", 32'(lcd_ack_cnt), 32'(cnt0));

        // Reset during an LCD access: strobes drop, no ack.
        lcd_set(22'h000040);
        step();
        check("t7_lcd_started", 32'(strb()), 32'(S_ROM_RD));
        reset_n = 1'b0;
        lcd_req = 1'b0;
        cnt0 = lcd_ack_cnt;
        step();
        check("t7_rst_strobes", 32'(strb()), 32'(S_NONE));
        check("t7_rst_ack", 32'(lcd_ack), 0);
        reset_n = 1'b1;
        void'(lcd_q.pop_back());
        repeat (4) step();
        check("t7_no_ack", 32'(lcd_ack_cnt), 32'(cnt0));

        // CPU read held through reset is granted again afterwards.
        cpu_set(1'b0, 22'h080123, 8'h00);
        step();
        check("t8_cpu_started", 32'(strb()), 32'(S_RAM_RD));
        reset_n = 1'b0;
        step();
        check("t8_rst_strobes", 32'(strb()), 32'(S_NONE));
        check("t8_rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
        check("t8_rst_wait", 32'(cpu_wait_n), 0);
        reset_n = 1'b1;
        k = 0;
        while (!cpu_wait_n && k < 20) begin
            step();
            k++;
        end
        check("t8_regrant_latency", 32'(k), ACC + 1);
        step();
        cpu_release();
        step();

        // Randomized mixed traffic.
        fork
            cpu_rand(40);
            lcd_rand(40);
        join
        repeat (8) step();
        check("cpu_q_drained", 32'(cpu_q.size()), 0);
        check("lcd_q_drained", 32'(lcd_q.size()), 0);
    endtask

    initial begin
        fork
            begin
                main_seq();
                sim_done = 1'b1;
            end
            begin
                while (!sim_done) monitor_cycle();
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
